// File: rtl/obuf_pkg.sv
// Shared constants, FSM state type and lane type for the output-buffer drain stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package obuf_pkg;

    localparam int DATA_W   = 1024;
    localparam int LANE_W   = 64;
    localparam int LANES    = DATA_W / LANE_W;
    localparam int ADDR_W   = 13;
    localparam int NUM_ROWS = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/obuf_lane_serializer.sv
// Row-to-lane serializer: loads one buffer row, presents it lane 0 first.
// Latency: lane 0 visible the cycle after load_i; one lane per advance_i.
// Backpressure: holds lane_o/last_o stable whenever advance_i is low.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i/row_i row load;
//        advance_i step to next lane; lane_o current lane; last_o final lane flag.
// Build option OBUF_DRAIN_RELU_EN: negative lanes are zeroed at load.
module obuf_lane_serializer #(
    parameter int DATA_W = obuf_pkg::DATA_W,
    parameter int LANE_W = obuf_pkg::LANE_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] row_i,
    input  logic              advance_i,
    output logic [LANE_W-1:0] lane_o,
    output logic              last_o
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int IDX_W = $clog2(LANES);

    logic [DATA_W-1:0] row_q, row_d, row_ld;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Optional rectification happens on the way in, so the shift path and
    // latency are identical in both builds.
    always_comb begin
        row_ld = row_i;
`ifdef OBUF_DRAIN_RELU_EN
        for (int l = 0; l < LANES; l++) begin
            if (row_i[l*LANE_W + LANE_W - 1]) begin
                row_ld[l*LANE_W +: LANE_W] = '0;
            end
        end
`endif
    end

    // Shift right so the presented lane is always the low register bits:
    // lane_o is a plain register output, no wide mux in front of it.
    always_comb begin
        row_d = row_q;
        idx_d = idx_q;
        if (load_i) begin
            row_d = row_ld;
            idx_d = '0;
        end else if (advance_i) begin
            row_d = row_q >> LANE_W;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            idx_q <= '0;
        end else begin
            row_q <= row_d;
            idx_q <= idx_d;
        end
    end

    assign lane_o = row_q[LANE_W-1:0];
    assign last_o = (idx_q == IDX_W'(LANES - 1));

endmodule

// File: rtl/obuf_drain.sv
// Output-buffer drain: reads a run of rows and streams each as 16 x 64-bit lanes.
// Latency: start -> READ +1, CAPT +2, first m_valid +3; 18 cycles per row at full rate.
// Backpressure: m_valid & !m_ready freezes lane, m_data/m_last and further reads.
// Ports: CLK/RST_N clock and async active-low reset; start/base_addr/row_cnt command;
//        busy/done status; buf_CEN/buf_A/buf_Q buffer read port (Q one cycle after CEN=0);
//        m_valid/m_ready/m_data/m_last output stream.
// Build option OBUF_DRAIN_RELU_EN: negative lanes are emitted as zero.
module obuf_drain #(
    parameter int DATA_W   = obuf_pkg::DATA_W,
    parameter int LANE_W   = obuf_pkg::LANE_W,
    parameter int ADDR_W   = obuf_pkg::ADDR_W,
    parameter int NUM_ROWS = obuf_pkg::NUM_ROWS
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [5:0]        row_cnt,
    output logic              busy,
    output logic              done,
    output logic              buf_CEN,
    output logic [ADDR_W-1:0] buf_A,
    input  logic [DATA_W-1:0] buf_Q,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last
);
    import obuf_pkg::*;

    // Row addresses wrap by keeping the low bits; NUM_ROWS is a power of two.
    localparam int ROW_AW = $clog2(NUM_ROWS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [5:0]        row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rd_sum;
    logic              busy_q, done_q, cen_q, vld_q;
    logic              advance, last_row, ser_last;
    logic [LANE_W-1:0] ser_lane;

    assign advance  = vld_q & m_ready;
    assign last_row = ((row_q + 6'd1) == cnt_q);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        addr_d  = addr_q;
        rd_sum  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    cnt_d   = row_cnt;
                    row_d   = '0;
                    state_d = (row_cnt != 6'd0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: state_d = ST_SEND;
            ST_SEND: begin
                if (advance && ser_last) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                        row_d   = row_q + 6'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Address is computed from next-state values so it is registered
        // alongside buf_CEN and both are valid throughout the READ cycle.
        if (state_d == ST_READ) begin
            rd_sum = base_d + ADDR_W'(row_d);
            addr_d = ADDR_W'(rd_sum[ROW_AW-1:0]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cen_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            cen_q   <= (state_d != ST_READ);
            vld_q   <= (state_d == ST_SEND);
        end
    end

    // buf_Q is only non-zero in CAPT, so the row is captured exactly then.
    obuf_lane_serializer #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_ser (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .load_i    (state_q == ST_CAPT),
        .row_i     (buf_Q),
        .advance_i (advance),
        .lane_o    (ser_lane),
        .last_o    (ser_last)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign buf_CEN = cen_q;
    assign buf_A   = addr_q;
    assign m_valid = vld_q;
    assign m_data  = ser_lane;
    assign m_last  = ser_last & last_row & vld_q;

endmodule

// File: tb/tb_obuf_drain.sv
// Directed plus randomized bench for obuf_drain with a queue-based reference model.
// Latency: n/a. Backpressure: m_ready driven per cycle from several patterns.
// Buffer memory is modelled here; it outputs zero when not selected.
module tb_obuf_drain;
    localparam int DATA_W = 1024;
    localparam int LANE_W = 64;
    localparam int LANES  = 16;
    localparam int ADDR_W = 13;
    localparam int NROWS  = 32;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [5:0]        row_cnt;
    logic              busy, done, buf_CEN, m_valid, m_ready, m_last;
    logic [ADDR_W-1:0] buf_A;
    logic [DATA_W-1:0] buf_Q = '0;
    logic [LANE_W-1:0] m_data;

    logic [DATA_W-1:0] mem [NROWS];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observation records, written only by the monitor.
    logic [63:0] words[$];
    bit          lasts[$];
    int          hs_cyc[$];
    int          rd_addr[$];
    int          rd_cyc[$];
    int          done_cyc[$];
    bit          busy_at_done[$];
    int          stall_viol = 0;
    int          cen_in_send = 0;
    int          bad_addr = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    bit          prev_last = 1'b0;

    obuf_drain dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .base_addr (base_addr),
        .row_cnt   (row_cnt),
        .busy      (busy),
        .done      (done),
        .buf_CEN   (buf_CEN),
        .buf_A     (buf_A),
        .buf_Q     (buf_Q),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) buf_Q <= (!buf_CEN) ? mem[buf_A[4:0]] : '0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stall_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                words.push_back(m_data);
                lasts.push_back(m_last);
                hs_cyc.push_back(cyc);
            end
            if (!buf_CEN) begin
                rd_addr.push_back(int'(buf_A));
                rd_cyc.push_back(cyc);
                if (m_valid) cen_in_send++;
                if (int'(buf_A) >= NROWS) bad_addr++;
            end
            if (done) begin
                done_cyc.push_back(cyc);
                busy_at_done.push_back(busy);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane_exp(input logic [DATA_W-1:0] row, input int l);
        logic [63:0] v;
        v = row[l*LANE_W +: LANE_W];
`ifdef OBUF_DRAIN_RELU_EN
        if (v[63]) v = '0;
`endif
        return v;
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            2:       return 1'(k & 1);
            default: return (k >= 24 && k < 29) ? 1'b0 : 1'(k & 1);
        endcase
    endfunction

    // Issues one command, drives m_ready per pattern, then compares everything
    // observed against the expected row/lane order built from the memory image.
    task automatic run_cmd(input int base, input int cnt, input int mode,
                           input bit repulse, input string nm, output int w0);
        logic [63:0] exp_w[$];
        int exp_r[$];
        int r0, d0, sv0, cs0, ba0, s, nw, nr;
        for (int r = 0; r < cnt; r++) begin
            exp_r.push_back((base + r) % NROWS);
            for (int l = 0; l < LANES; l++)
                exp_w.push_back(lane_exp(mem[(base + r) % NROWS], l));
        end
        w0 = words.size(); r0 = rd_addr.size(); d0 = done_cyc.size();
        sv0 = stall_viol; cs0 = cen_in_send; ba0 = bad_addr;

        @(posedge CLK); #1;
        start = 1'b1; base_addr = ADDR_W'(base); row_cnt = 6'(cnt);
        m_ready = ready_for(mode, 0);
        s = cyc;
        @(posedge CLK); #1;
        start = 1'b0;
        chk({nm, "_busy_after_start"}, 64'(busy), 64'd1);
        for (int k = 1; k < 4000; k++) begin
            m_ready = ready_for(mode, k);
            if (repulse && k == 10) begin
                start = 1'b1; row_cnt = 6'd5; base_addr = 13'd0;
            end else begin
                start = 1'b0;
            end
            if (done_cyc.size() > d0) break;
            @(posedge CLK); #1;
        end
        start = 1'b0;
        m_ready = 1'b1;

        chk({nm, "_done_pulses"}, 64'(done_cyc.size() - d0), 64'd1);
        chk({nm, "_busy_after_done"}, 64'(busy), 64'd0);
        chk({nm, "_done_low_after"}, 64'(done), 64'd0);
        if (done_cyc.size() > d0)
            chk({nm, "_busy_in_done"}, 64'(busy_at_done[d0]), 64'd1);

        nw = words.size() - w0;
        nr = rd_addr.size() - r0;
        chk({nm, "_word_count"}, 64'(nw), 64'(exp_w.size()));
        for (int i = 0; i < nw && i < exp_w.size(); i++) begin
            chk($sformatf("%s_word%0d", nm, i), words[w0 + i], exp_w[i]);
            chk($sformatf("%s_last%0d", nm, i), 64'(lasts[w0 + i]), 64'(i == exp_w.size() - 1));
        end
        chk({nm, "_read_count"}, 64'(nr), 64'(cnt));
        for (int i = 0; i < nr && i < cnt; i++)
            chk($sformatf("%s_read_addr%0d", nm, i), 64'(rd_addr[r0 + i]), 64'(exp_r[i]));
        chk({nm, "_stall_hold"}, 64'(stall_viol - sv0), 64'd0);
        chk({nm, "_no_read_in_send"}, 64'(cen_in_send - cs0), 64'd0);
        chk({nm, "_addr_range"}, 64'(bad_addr - ba0), 64'd0);

        // Full-rate timing: row r read at s+1+18r, first word at s+3, done at s+1+18*cnt.
        if (mode == 0) begin
            if (done_cyc.size() > d0)
                chk({nm, "_done_cycle"}, 64'(done_cyc[d0]), 64'(s + 1 + 18 * cnt));
            for (int i = 0; i < nr && i < cnt; i++)
                chk($sformatf("%s_read_cyc%0d", nm, i), 64'(rd_cyc[r0 + i]), 64'(s + 1 + 18 * i));
            if (cnt > 0 && nw > 0)
                chk({nm, "_first_word_cyc"}, 64'(hs_cyc[w0]), 64'(s + 3));
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"},    64'(busy),    64'd0);
        chk({nm, "_done"},    64'(done),    64'd0);
        chk({nm, "_cen"},     64'(buf_CEN), 64'd1);
        chk({nm, "_addr"},    64'(buf_A),   64'd0);
        chk({nm, "_valid"},   64'(m_valid), 64'd0);
        chk({nm, "_data"},    m_data,       64'd0);
        chk({nm, "_last"},    64'(m_last),  64'd0);
    endtask

    initial begin
        int w0;
        int b, c, m;
        logic [63:0] relu_neg;
        logic [63:0] exp_neg;

        RST_N = 1'b1; start = 1'b0; base_addr = '0; row_cnt = '0; m_ready = 1'b1;
        for (int a = 0; a < NROWS; a++)
            for (int l = 0; l < LANES; l++)
                mem[a][l*LANE_W +: LANE_W] = {$urandom, $urandom};
        for (int l = 0; l < LANES; l++)
            mem[3][l*LANE_W +: LANE_W] = 64'h100 + 64'(l);
        relu_neg = 64'hFFFF_FFFF_FFFF_FFF0;
        mem[10][0 +: LANE_W]      = relu_neg;
        mem[10][LANE_W +: LANE_W] = 64'h7;

        #1 RST_N = 1'b0;
        #2;
        chk_reset_outputs("reset0");
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;

        // Single row with known lane values.
        run_cmd(3, 1, 0, 1'b0, "single", w0);
        if (words.size() >= w0 + 16) begin
            chk("single_first_val", words[w0], 64'h100);
            chk("single_last_val", words[w0 + 15], 64'h10F);
        end

        // Address wrap 30,31,0,1.
        run_cmd(30, 4, 0, 1'b0, "wrap", w0);

        // Backpressure: alternating ready, then alternating with a 5-cycle hold.
        run_cmd(5, 2, 2, 1'b0, "toggle", w0);
        run_cmd(12, 2, 3, 1'b0, "hold5", w0);

        // Zero-length command and start re-pulsed while busy.
        run_cmd(9, 0, 0, 1'b0, "zero", w0);
        run_cmd(2, 3, 1, 1'b1, "repulse", w0);

        // Rectification of a negative lane and pass-through of a positive one.
        run_cmd(10, 1, 0, 1'b0, "relu", w0);
`ifdef OBUF_DRAIN_RELU_EN
        exp_neg = 64'd0;
`else
        exp_neg = relu_neg;
`endif
        if (words.size() >= w0 + 2) begin
            chk("relu_neg_lane", words[w0], exp_neg);
            chk("relu_pos_lane", words[w0 + 1], 64'h7);
        end

        // Random commands and ready patterns.
        for (int i = 0; i < 6; i++) begin
            b = $urandom_range(0, NROWS - 1);
            c = $urandom_range(1, 8);
            m = $urandom_range(0, 3);
            run_cmd(b, c, m, 1'b0, $sformatf("rand%0d", i), w0);
        end

        // Whole buffer.
        run_cmd(17, 32, 0, 1'b0, "full", w0);

        // Reset while lane 7 of the second row is presented.
        @(posedge CLK); #1;
        start = 1'b1; base_addr = 13'd7; row_cnt = 6'd3; m_ready = 1'b1;
        w0 = words.size();
        @(posedge CLK); #1;
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (words.size() - w0 >= 23) break;
            @(posedge CLK); #1;
        end
        chk("rst_mid_words_before", 64'(words.size() - w0), 64'd23);
        chk("rst_mid_valid_before", 64'(m_valid), 64'd1);
        chk("rst_mid_lane7", m_data, lane_exp(mem[8], 7));
        #2 RST_N = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;
        run_cmd(20, 2, 0, 1'b0, "after_rst", w0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
